// File: rtl/ricosoc_bus_pkg.sv
// Shared definitions for the SoC native-bus arbiter and its watchdog.
package ricosoc_bus_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned MIDX_W = 1;
  typedef logic [MIDX_W-1:0] midx_t;

  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ricosoc_bus_watchdog.sv
// Up-counting watchdog: synchronous clear, count enable, terminal-count flag.
module ricosoc_bus_watchdog #(
  parameter int unsigned TERMINAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CNT_W-1:0] count_q;

  // Clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Terminal count is decoded directly from the counter.
  always_comb begin
    tc_o = (count_q == CNT_W'(TERMINAL - 1));
  end

endmodule

// File: rtl/ricosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the SoC native memory bus with
// whole-transfer grant lock and a watchdog that forces completion of hung
// transfers and raises a sticky timeout interrupt.
module ricosoc_bus_arbiter
  import ricosoc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  input  logic        err_clr,
  output logic        timeout_irq,
  output logic        timeout_master
);

  arb_state_e state_q;
  midx_t      grant_q;
  midx_t      last_grant_q;
  logic       timeout_irq_q;
  midx_t      timeout_master_q;

  midx_t      grant_d;
  logic       wd_tc;
  logic       timeout_fire;
  logic       xfer_done;
  logic [31:0] done_rdata;

  // Watchdog is held clear while idle so it always starts at zero in BUSY.
  ricosoc_bus_watchdog #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (resetn),
    .clr_i (state_q == ARB_IDLE),
    .en_i  (state_q == ARB_BUSY),
    .tc_o  (wd_tc)
  );

  // Round-robin pick: on a tie the master that did not win last goes next.
  always_comb begin
    grant_d = '0;
    if (m0_valid && m1_valid) begin
      grant_d = ~last_grant_q;
    end else if (m1_valid) begin
      grant_d = 1'b1;
    end
  end

  // Completion qualifiers; s_ready on the terminal cycle beats the timeout.
  always_comb begin
    timeout_fire = (state_q == ARB_BUSY) && wd_tc && !s_ready;
    xfer_done    = (state_q == ARB_BUSY) && (s_ready || wd_tc);
    done_rdata   = s_ready ? s_rdata : TIMEOUT_RDATA;
  end

  // Arbitration FSM plus sticky timeout status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ARB_IDLE;
      grant_q          <= '0;
      last_grant_q     <= 1'b1;
      timeout_irq_q    <= 1'b0;
      timeout_master_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (m0_valid || m1_valid) begin
            grant_q <= grant_d;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (xfer_done) begin
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase

      if (timeout_fire) begin
        timeout_irq_q    <= 1'b1;
        timeout_master_q <= grant_q;
      end else if (err_clr) begin
        timeout_irq_q    <= 1'b0;
      end
    end
  end

  // Slave-side mux and master-side return path, all zero without a grant.
  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    if (state_q == ARB_BUSY) begin
      s_valid = !timeout_fire;
      if (grant_q == 1'b0) begin
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = xfer_done;
        m0_rdata = xfer_done ? done_rdata : '0;
      end else begin
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = xfer_done;
        m1_rdata = xfer_done ? done_rdata : '0;
      end
    end
  end

  // Registered status outputs.
  always_comb begin
    timeout_irq    = timeout_irq_q;
    timeout_master = timeout_master_q;
  end

endmodule
